// File: rtl/riscv_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_loader_pkg
//  Description : Shared constants, FSM state encoding and helper function
//                for the host-to-instruction-memory program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_loader_pkg;

    localparam int INSTR_W        = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_FULL    = 2'd3
    } loader_state_t;

    // True when the index points at the most significant byte of a word.
    function automatic logic is_last_byte(input logic [BYTE_IDX_W-1:0] idx);
        return idx == BYTE_IDX_W'(BYTES_PER_WORD - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader_byte_packer
//  Description : Little-endian byte packer. Holds bytes 0..2 of the word in
//                progress plus a byte index; the full word is presented
//                combinationally while byte 3 is on the input.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_loader_byte_packer
    import riscv_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               accept_i,
    input  logic [7:0]         byte_i,
    output logic               last_o,
    output logic [INSTR_W-1:0] word_o
);

    logic [BYTE_IDX_W-1:0] idx_q;
    logic [INSTR_W-9:0]    partial_q;

    // Store each accepted byte in its lane and advance the index; clear drops a partial word.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            idx_q     <= '0;
            partial_q <= '0;
        end else if (accept_i) begin
            case (idx_q)
                2'd0:    partial_q[7:0]   <= byte_i;
                2'd1:    partial_q[15:8]  <= byte_i;
                2'd2:    partial_q[23:16] <= byte_i;
                default: partial_q        <= partial_q;
            endcase
            idx_q <= idx_q + 1'b1;
        end
    end

    assign last_o = is_last_byte(idx_q);
    assign word_o = {byte_i, partial_q};

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader
//  Description : Streams program bytes from host pins into instruction
//                memory as 32-bit little-endian words while holding the CPU
//                in reset. Optional running XOR checksum enabled by the
//                macro INSTR_LOADER_CHECKSUM_EN (default: disabled, tied 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_loader
    import riscv_loader_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int MAX_WORDS = 2 ** ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic               byte_valid,
    input  logic [7:0]         byte_in,
    output logic               byte_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic [ADDR_W:0]    word_count,
    output logic               cpu_hold,
    output logic               overflow,
    output logic [7:0]         checksum
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

    loader_state_t      state_q;
    logic [ADDR_W:0]    word_count_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [INSTR_W-1:0] mem_wdata_q;
    logic               overflow_q;

    logic               byte_accept;
    logic               pack_clear;
    logic               pack_last;
    logic [INSTR_W-1:0] pack_word;
    logic [ADDR_W:0]    count_inc;

    assign byte_ready  = (state_q == ST_COLLECT);
    assign byte_accept = byte_valid & byte_ready;
    // Any state other than COLLECT leaves the packer empty, so an abort
    // through IDLE discards a partial word.
    assign pack_clear  = (state_q != ST_COLLECT);
    assign count_inc   = word_count_q + 1'b1;

    instr_loader_byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (pack_clear),
        .accept_i (byte_accept),
        .byte_i   (byte_in),
        .last_o   (pack_last),
        .word_o   (pack_word)
    );

    // Loader FSM with registered memory-write outputs, word counter and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_en) begin
                        state_q      <= ST_COLLECT;
                        word_count_q <= '0;
                        overflow_q   <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (!load_en) begin
                        state_q <= ST_IDLE;
                    end else if (byte_accept && pack_last) begin
                        state_q     <= ST_WRITE;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= word_count_q[ADDR_W-1:0];
                        mem_wdata_q <= pack_word;
                    end
                end
                ST_WRITE: begin
                    // The write already issued is never cancelled.
                    word_count_q <= count_inc;
                    if (!load_en) begin
                        state_q <= ST_IDLE;
                    end else if (count_inc == MAX_CNT) begin
                        state_q <= ST_FULL;
                    end else begin
                        state_q <= ST_COLLECT;
                    end
                end
                ST_FULL: begin
                    if (byte_valid) begin
                        overflow_q <= 1'b1;
                    end
                    if (!load_en) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] checksum_q;

    // Running XOR of accepted bytes, restarted at each load start.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= 8'h00;
        end else if ((state_q == ST_IDLE) && load_en) begin
            checksum_q <= 8'h00;
        end else if (byte_accept) begin
            checksum_q <= checksum_q ^ byte_in;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 8'h00;
`endif

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;
    assign overflow   = overflow_q;
    assign cpu_hold   = rst | load_en | (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_loader
//  Description : Self-checking bench for instr_loader (ADDR_W=2, 4 words).
//                A queue-based behavioural model is compared against the
//                DUT every cycle; directed scenarios add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    localparam int AW   = 2;
    localparam int MAXW = 4;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          load_en;
    logic          byte_valid;
    logic [7:0]    byte_in;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   word_count;
    logic          cpu_hold;
    logic          overflow;
    logic [7:0]    checksum;

    instr_loader #(.ADDR_W(AW), .MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count),
        .cpu_hold   (cpu_hold),
        .overflow   (overflow),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_seen_rst = 1'b0;
    bit          m_active   = 1'b0;   // loader engaged with host
    bit          m_writing  = 1'b0;   // a word is being written this cycle
    bit          m_full     = 1'b0;   // memory quota reached
    logic [7:0]  m_bytes[$];          // bytes of the word in progress
    int          m_count    = 0;
    bit          m_ovf      = 1'b0;
    logic [7:0]  m_cks      = 8'h00;
    bit          m_we       = 1'b0;
    int          m_addr     = 0;
    logic [31:0] m_wdata    = 32'h0;

    // Observed writes, in order.
    int          log_addr[$];
    logic [31:0] log_data[$];

    task model_step();
        if (rst) begin
            m_seen_rst = 1'b1;
            m_active = 0; m_writing = 0; m_full = 0;
            m_bytes.delete();
            m_count = 0; m_ovf = 0; m_cks = 8'h00;
            m_we = 0; m_addr = 0; m_wdata = 32'h0;
        end else if (m_seen_rst) begin
            if (m_writing) begin
                m_we = 0;
                m_writing = 0;
                m_count = m_count + 1;
                if (!load_en) m_active = 0;
                else if (m_count == MAXW) m_full = 1;
            end else if (!m_active) begin
                if (load_en) begin
                    m_active = 1; m_full = 0;
                    m_count = 0; m_ovf = 0; m_cks = 8'h00;
                    m_bytes.delete();
                end
            end else if (m_full) begin
                if (byte_valid) m_ovf = 1;
                if (!load_en) begin
                    m_active = 0;
                    m_full = 0;
                end
            end else begin
                if (byte_valid) begin
                    m_bytes.push_back(byte_in);
                    m_cks = m_cks ^ byte_in;
                end
                if (!load_en) begin
                    m_active = 0;
                    m_bytes.delete();
                end else if (m_bytes.size() == 4) begin
                    m_wdata = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    m_addr = m_count;
                    m_we = 1;
                    m_writing = 1;
                    m_bytes.delete();
                end
            end
        end
    endtask

    // Advance the model on each edge, then compare shortly after it.
    always @(posedge clk) begin
        model_step();
        #1;
        if (m_seen_rst) begin
            check("byte_ready", byte_ready, m_active && !m_writing && !m_full);
            check("mem_we",     mem_we, m_we);
            check("mem_addr",   mem_addr, m_addr);
            check("mem_wdata",  mem_wdata, m_wdata);
            check("word_count", word_count, m_count);
            check("overflow",   overflow, m_ovf);
            check("checksum",   checksum, CKS_EN ? m_cks : 8'h00);
            check("cpu_hold",   cpu_hold, rst | load_en | m_active);
            if (mem_we === 1'b1) begin
                log_addr.push_back(int'(mem_addr));
                log_data.push_back(mem_wdata);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit took;
        took = 1'b0;
        byte_valid = 1'b1;
        byte_in = b;
        for (int i = 0; i < 40 && !took; i++) begin
            took = (byte_ready === 1'b1);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        if (!took) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte %0h not accepted, required acceptance", b);
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic start_load();
        load_en = 1'b0;
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
    endtask

    int n0;

    initial begin
        rst = 1'b1; load_en = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
        repeat (3) @(negedge clk);
        // Reset state, with load_en high to show rst dominates.
        check("rst_cpu_hold",   cpu_hold, 1'b1);
        check("rst_mem_we",     mem_we, 1'b0);
        check("rst_word_count", word_count, 0);
        check("rst_byte_ready", byte_ready, 1'b0);
        check("rst_overflow",   overflow, 1'b0);
        check("rst_wdata",      mem_wdata, 32'h0);
        rst = 1'b0; load_en = 1'b0;
        @(negedge clk);

        // Single instruction word, consecutive bytes.
        load_en = 1'b1;
        @(negedge clk);
        send_byte(8'h13, 0); send_byte(8'h00, 0);
        send_byte(8'h50, 0); send_byte(8'h00, 0);
        check("A_we",    mem_we, 1'b1);
        check("A_addr",  mem_addr, 0);
        check("A_wdata", mem_wdata, 32'h00500013);
        @(negedge clk);
        check("A_count", word_count, 1);
        check("A_we_off", mem_we, 1'b0);

        // Eight bytes with byte_valid toggling.
        start_load();
        n0 = log_data.size();
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i), 1);
        repeat (2) @(negedge clk);
        check("B_nwrites", log_data.size() - n0, 2);
        if (log_data.size() - n0 == 2) begin
            check("B_addr0", log_addr[n0],     0);
            check("B_data0", log_data[n0],     32'h14131211);
            check("B_addr1", log_addr[n0 + 1], 1);
            check("B_data1", log_data[n0 + 1], 32'h18171615);
        end
        check("B_count", word_count, 2);

        // Partial word abandoned, then a fresh load.
        start_load();
        n0 = log_data.size();
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        check("C_no_partial", log_data.size() - n0, 0);
        load_en = 1'b1;
        @(negedge clk);
        send_byte(8'hA1, 0); send_byte(8'hA2, 0);
        send_byte(8'hA3, 0); send_byte(8'hA4, 0);
        @(negedge clk);
        check("C_nwrites", log_data.size() - n0, 1);
        if (log_data.size() - n0 == 1) begin
            check("C_addr", log_addr[n0], 0);
            check("C_data", log_data[n0], 32'hA4A3A2A1);
        end

        // Fill memory: 16 accepted bytes then 4 more offered.
        start_load();
        n0 = log_data.size();
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 0);
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            byte_in = 8'h30 + 8'(i);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        @(negedge clk);
        check("D_nwrites", log_data.size() - n0, 4);
        if (log_data.size() - n0 == 4) begin
            for (int i = 0; i < 4; i++) check("D_addr", log_addr[n0 + i], i);
            check("D_data3", log_data[n0 + 3], 32'h2F2E2D2C);
        end
        check("D_ready",    byte_ready, 1'b0);
        check("D_overflow", overflow, 1'b1);
        check("D_count",    word_count, 4);
        check("D_hold",     cpu_hold, 1'b1);

        // Reset in the cycle byte 3 is accepted.
        start_load();
        n0 = log_data.size();
        send_byte(8'h51, 0); send_byte(8'h52, 0); send_byte(8'h53, 0);
        byte_valid = 1'b1; byte_in = 8'h54; rst = 1'b1;
        @(negedge clk);
        check("E_we",       mem_we, 1'b0);
        check("E_addr",     mem_addr, 0);
        check("E_wdata",    mem_wdata, 32'h0);
        check("E_count",    word_count, 0);
        check("E_overflow", overflow, 1'b0);
        check("E_checksum", checksum, 8'h00);
        check("E_ready",    byte_ready, 1'b0);
        check("E_hold",     cpu_hold, 1'b1);
        byte_valid = 1'b0; rst = 1'b0; load_en = 1'b0;
        @(negedge clk);
        check("E_no_write", log_data.size() - n0, 0);

        // Checksum of 01,02,04,08.
        start_load();
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        send_byte(8'h04, 0); send_byte(8'h08, 0);
        check("F_wdata", mem_wdata, 32'h08040201);
        @(negedge clk);
        check("F_checksum", checksum, CKS_EN ? 8'h0F : 8'h00);

        load_en = 1'b0;
        repeat (3) @(negedge clk);
        check("G_released", cpu_hold, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
